io_conditioner: RTL
===================

# io_conditioner

Input-conditioning stage that sits between the raw TinyTapeout pins and the benchmark wrapper. It synchronises, debounces and edge-detects the user inputs (io_in[7:2]). The wrapper consumes stable levels (data bits and the 3-bit output selector) plus single-cycle rise/fall strobes. These strobes drive shift_enable, roll and enable style controls without metastability or bounce.

## Interface
- WIDTH, 6: number of conditioned input bits (maps to io_in[7:2]); must be ≥ 3.
- DEBOUNCE_CYCLES, 16: consecutive synchronised cycles a new value must hold before acceptance; must be ≥ 1.

- clk  input  1  single clock (io_in[0]); all state on rising edge.
- reset_n  input  1  reset, asynchronous and active-low (io_in[1]).
- raw_in  input  WIDTH  unsynchronised pin values.
- level  output  WIDTH  debounced stable level per bit.
- rise  output  WIDTH  one-cycle pulse per bit when its level goes 0→1.
- fall  output  WIDTH  one-cycle pulse per bit when its level goes 1→0.
- sel_change  output  1  one-cycle pulse when any of level[WIDTH-1:WIDTH-3] (selector bits) changes.

## Operation
- Every bit is handled identically and independently; no cross-bit interaction except sel_change.
- Per bit: 2-flop synchroniser s1←raw, s2←s1.
- Per bit: debounce counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
- Each edge with s2 == level: cnt←0. Any disagreement shorter than DEBOUNCE_CYCLES is discarded (glitch rejection).
- Each edge with s2 != level and cnt < DEBOUNCE_CYCLES-1: cnt←cnt+1.
- Each edge with s2 != level and cnt == DEBOUNCE_CYCLES-1:
  - level←s2 and cnt←0.
  - rise←s2 and fall←~s2, both registered on this same edge.
- rise/fall are 0 on every other edge. They are never both high for one bit.
- sel_change is registered as the OR of (rise|fall) over the top 3 bits. It is therefore one edge after the corresponding rise/fall.
- Simultaneous changes on several bits are accepted independently. Pulses can coincide.
- Reset asserted (any time, mid-count included): s1, s2, cnt, level, rise, fall and sel_change clear to 0 immediately.
- After reset release, pins held high are treated as new 0→1 changes and produce rise pulses after the full latency.

## Timing
- Reset values: level=0, rise=0, fall=0, sel_change=0.
- Let edge k be the first rising edge that samples a new raw value.
  - s2 holds the new value after edge k+1.
  - level changes and the rise/fall pulse appear at edge k+1+DEBOUNCE_CYCLES, i.e. the (DEBOUNCE_CYCLES+2)th edge.
  - sel_change appears at edge k+2+DEBOUNCE_CYCLES.
- Pulse width: exactly one clock.
- Minimum spacing between two accepted changes on one bit: DEBOUNCE_CYCLES cycles.

## Configuration
- IO_COND_DEBOUNCE_EN defined: debounce counter as described above.
- IO_COND_DEBOUNCE_EN undefined: no counter.
  - level←s2 every edge; DEBOUNCE_CYCLES is ignored.
  - rise/fall fire on the edge where level changes, i.e. edge k+2 (3rd edge); sel_change fires at edge k+3.
  - Every level change produces a pulse, including single-cycle glitches.

## Structure
- Package io_cond_pkg holds:
  - the DEBOUNCE_CYCLES default;
  - the SEL_BITS=3 constant;
  - a counter-width function returning $clog2(DEBOUNCE_CYCLES+1).
- Sub-module debounce_bit covers one bit (synchroniser, counter, level, rise, fall). io_conditioner instantiates it WIDTH times in a generate loop and adds the sel_change register.

## Test plan
- Bench parameters: WIDTH=6, DEBOUNCE_CYCLES=4.
- Reset, then raw_in=6'b000001 set before edge 1 and held:
  - level[0]=1 and rise[0]=1 for one cycle at edge 6;
  - level[0]=0 and rise=0 at edges 1–5;
  - sel_change stays 0.
- Bit 1 high for 3 cycles (after sync) then low → level[1], rise[1], fall[1] never assert. Repeat with 4 cycles → accepted at the 6th edge.
- raw_in[5:3]: 000→101 → rise[5]=rise[3]=1 on the same edge; sel_change=1 one edge later for exactly one cycle.
- Bit 2 at count 3 of 4 with reset_n pulsed low:
  - all outputs 0 immediately;
  - after release with the bit still high, rise[2] appears 6 edges later.
- Accepted 1→0 on bit 4 → fall[4]=1, rise[4]=0, level[4]=0 at the 6th edge.
- Build without IO_COND_DEBOUNCE_EN, 1-cycle glitch on bit 0 → rise[0] at edge 3, fall[0] at edge 4.

Source files
------------

// File: rtl/io_cond_pkg.sv
// rtl/io_cond_pkg.sv - shared constants and helpers for the input conditioner
package io_cond_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int SEL_BITS                = 3;

    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one-bit synchroniser, debouncer and edge strobes
// IO_COND_DEBOUNCE_EN selects the counted debounce; otherwise the synchronised value passes straight through
module debounce_bit
    import io_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
        $error("debounce_bit: DEBOUNCE_CYCLES must be at least 1");
    end

    logic s1_q, s2_q;
    logic level_q, level_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef IO_COND_DEBOUNCE_EN
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Any return to agreement clears the count, so short disagreements leave no trace.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        level_d = s2_q;
        rise_d  = s2_q & ~level_q;
        fall_d  = ~s2_q & level_q;
    end
`endif

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/io_conditioner.sv
// rtl/io_conditioner.sv - per-pin conditioning plus selector-change strobe (debounce under IO_COND_DEBOUNCE_EN)
module io_conditioner
    import io_cond_pkg::*;
#(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             sel_change
);

    if (WIDTH < SEL_BITS) begin : g_cfg_err
        $error("io_conditioner: WIDTH must cover the selector bits");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .raw_i  (raw_in[i]),
            .level_o(level[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    logic sel_change_q, sel_change_d;

    // Selector bits are the top of the vector; the strobe trails their edge pulses by one clock.
    always_comb begin
        sel_change_d = |(rise[WIDTH-1 -: SEL_BITS] | fall[WIDTH-1 -: SEL_BITS]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_change_q <= 1'b0;
        end else begin
            sel_change_q <= sel_change_d;
        end
    end

    assign sel_change = sel_change_q;

endmodule
